// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: aligned 8-byte reads into a circular byte
// queue, presenting a 10-byte window at the fetch PC.
module instr_prefetch_buffer #(
  parameter int DEPTH  = 24,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic [79:0]       instr,
  output logic              instr_valid,
  input  logic              instr_take,
  input  logic [3:0]        instr_len,
  output logic              instr_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_rerr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_e;

  typedef logic [PW:0] idx_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2:0]        skip_q, skip_d;
  logic              err_q, err_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [7:0]        buf_q [DEPTH];

  logic              redirect;
  logic              take_ok;
  logic              append;
  logic [3:0]        app_len;
  idx_t              wbase;

  function automatic logic [PW-1:0] wrap(input idx_t v);
    idx_t r;
    r = (v >= idx_t'(DEPTH)) ? v - idx_t'(DEPTH) : v;
    return r[PW-1:0];
  endfunction

  assign redirect    = fetch_pc != head_q;
  assign instr_valid = ~redirect & (count_q >= CW'(10));
  assign instr_err   = err_q & ~redirect & (count_q < CW'(10));
  assign mem_addr    = fill_q;
  assign mem_req     = (state_q == IDLE) & ~redirect & ~err_q
                     & (count_q <= CW'(DEPTH - 8));
  assign take_ok     = instr_take & instr_valid
                     & (instr_len != 4'd0) & (instr_len <= 4'd10);
  assign app_len     = 4'd8 - {1'b0, skip_q};
  // Appended byte j lands at tail + (j - skip); j >= skip keeps it in range.
  assign wbase       = idx_t'(rptr_q) + idx_t'(count_q) - idx_t'(skip_q);

  always_comb begin
    instr = '0;
    if (instr_valid) begin
      for (int i = 0; i < 10; i++) begin
        instr[79-8*i -: 8] = buf_q[wrap(idx_t'(rptr_q) + idx_t'(i))];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    fill_d  = fill_q;
    count_d = count_q;
    skip_d  = skip_q;
    err_d   = err_q;
    rptr_d  = rptr_q;
    append  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mem_req && mem_gnt) begin
          state_d = WAIT;
          fill_d  = fill_q + ADDR_W'(8);
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          if (!redirect) begin
            if (mem_rerr) err_d  = 1'b1;
            else          append = 1'b1;
          end
        end else if (redirect) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      head_d  = fetch_pc;
      fill_d  = {fetch_pc[ADDR_W-1:3], 3'b000};
      count_d = '0;
      skip_d  = fetch_pc[2:0];
      err_d   = 1'b0;
      rptr_d  = '0;
    end else begin
      count_d = count_q
              - (take_ok ? CW'(instr_len) : CW'(0))
              + (append  ? CW'(app_len)   : CW'(0));
      if (take_ok) begin
        head_d = head_q + ADDR_W'(instr_len);
        rptr_d = wrap(idx_t'(rptr_q) + idx_t'(instr_len));
      end
      if (append) skip_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      head_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      skip_q  <= '0;
      err_q   <= 1'b0;
      rptr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
      rptr_q  <= rptr_d;
      if (append) begin
        for (int j = 0; j < 8; j++) begin
          if (3'(j) >= skip_q) begin
            buf_q[wrap(wbase + idx_t'(j))] <= mem_rdata[8*j +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Randomised bench for instr_prefetch_buffer against a byte-count model
// and a functional instruction memory.
module tb_instr_prefetch_buffer;

  localparam int DEPTH = 24;
  localparam int AW    = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] fetch_pc;
  logic [79:0]   instr;
  logic          instr_valid;
  logic          instr_take;
  logic [3:0]    instr_len;
  logic          instr_err;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [63:0]   mem_rdata;
  logic          mem_rerr;

  always #5 clk = ~clk;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_pc   (fetch_pc),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_take (instr_take),
    .instr_len  (instr_len),
    .instr_err  (instr_err),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_rerr   (mem_rerr)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [79:0] got,
                     input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] membyte(input logic [63:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  function automatic logic [63:0] memword(input logic [63:0] a);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = membyte(a + 64'(k));
    return w;
  endfunction

  function automatic logic [79:0] window(input logic [63:0] a);
    logic [79:0] w;
    for (int i = 0; i < 10; i++) w[79-8*i -: 8] = membyte(a + 64'(i));
    return w;
  endfunction

  // model: bytes held from m_head onward, read status 0 none/1 live/2 stale
  logic [63:0] m_head, m_fill;
  int          m_cnt, m_skip, m_out;
  bit          m_err;
  bit          r_pend;
  logic [63:0] r_addr;
  int          r_dly;

  int          g_mode, d_mode, err_pct, take_mode, err_cd;
  int          f_len;
  bit          rnd_redir, redir_req, late_rv;
  logic [63:0] redir_pc;

  bit          e_valid, e_req, e_err, rv_now;
  logic [79:0] e_instr;
  logic [79:0] obs_instr;
  logic [63:0] obs_addr;
  bit          obs_valid, obs_req, obs_err;

  task automatic model_reset();
    m_head = '0; m_fill = '0; m_cnt = 0; m_skip = 0; m_out = 0;
    m_err = 1'b0; r_pend = 1'b0; r_dly = 0; err_cd = 0;
  endtask

  task automatic cycle();
    bit redir, grant;
    int app, tk;
    @(negedge clk);
    if (redir_req) begin
      fetch_pc  = redir_pc;
      redir_req = 1'b0;
    end else if (rnd_redir && $urandom_range(0, 49) == 0) begin
      case ($urandom_range(0, 2))
        0:       fetch_pc = 64'($urandom_range(0, 255));
        1:       fetch_pc = {$urandom, $urandom};
        default: fetch_pc = 64'hFFFF_FFFF_FFFF_FFF0
                          + 64'($urandom_range(0, 15));
      endcase
    end else begin
      fetch_pc = m_head;
    end
    e_valid = (fetch_pc == m_head) && (m_cnt >= 10);
    e_err   = m_err && (fetch_pc == m_head) && (m_cnt < 10);
    e_req   = (m_out == 0) && (fetch_pc == m_head) && !m_err
            && (DEPTH - m_cnt >= 8);
    e_instr = e_valid ? window(fetch_pc) : '0;
    case (take_mode)
      0: begin
        instr_take = $urandom_range(0, 99) < 60;
        instr_len  = ($urandom_range(0, 9) == 0)
                   ? 4'($urandom_range(0, 1) * 11)
                   : 4'($urandom_range(1, 10));
      end
      1: begin instr_take = 1'b0; instr_len = 4'd10; end
      default: begin instr_take = 1'b1; instr_len = 4'(f_len); end
    endcase
    case (g_mode)
      0:       mem_gnt = $urandom_range(0, 99) < 70;
      1:       mem_gnt = 1'b1;
      default: mem_gnt = 1'b0;
    endcase
    rv_now     = r_pend && (r_dly == 0);
    mem_rvalid = rv_now || late_rv;
    mem_rdata  = rv_now ? memword(r_addr) : {$urandom, $urandom};
    mem_rerr   = rv_now && ((err_cd == 1)
               || (int'($urandom_range(0, 99)) < err_pct));
    late_rv    = 1'b0;
    #1;
    obs_instr = instr;  obs_valid = instr_valid; obs_err = instr_err;
    obs_req   = mem_req; obs_addr = mem_addr;
    chk("valid", 80'(obs_valid), 80'(e_valid));
    chk("instr", obs_instr, e_instr);
    chk("err",   80'(obs_err), 80'(e_err));
    chk("req",   80'(obs_req), 80'(e_req));
    if (e_req) chk("addr", 80'(obs_addr), 80'(m_fill));
    @(posedge clk);
    redir = fetch_pc != m_head;
    grant = e_req && mem_gnt;
    app   = 0;
    if (mem_rvalid && m_out != 0) begin
      if (m_out == 1 && !redir) begin
        if (mem_rerr) m_err = 1'b1;
        else          app   = 8 - m_skip;
      end
      m_out = 0;
    end
    tk = (instr_take && e_valid && instr_len >= 1 && instr_len <= 10)
       ? int'(instr_len) : 0;
    if (redir) begin
      m_head = fetch_pc;
      m_fill = {fetch_pc[63:3], 3'b000};
      m_cnt  = 0;
      m_skip = int'(fetch_pc[2:0]);
      m_err  = 1'b0;
      if (m_out == 1) m_out = 2;
    end else begin
      m_cnt  = m_cnt - tk + app;
      m_head = m_head + 64'(tk);
      if (app != 0) m_skip = 0;
    end
    if (rv_now && err_cd > 0) err_cd--;
    if (rv_now) r_pend = 1'b0;
    else if (r_pend && r_dly > 0) r_dly--;
    if (grant) begin
      r_pend = 1'b1;
      r_addr = m_fill;
      r_dly  = (d_mode < 0) ? int'($urandom_range(0, 2)) : d_mode;
      m_out  = 1;
      m_fill = m_fill + 64'd8;
    end
  endtask

  task automatic run_until_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (m_cnt < 10 && n < budget) begin cycle(); n++; end
    if (m_cnt < 10) chk(tag, 80'd0, 80'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((m_out != 0 || r_pend) && n < 20) begin cycle(); n++; end
    if (m_out != 0 || r_pend) chk(tag, 80'd0, 80'd1);
  endtask

  initial begin
    int lens[5];
    int n;
    lens = '{1, 2, 9, 10, 3};
    g_mode = 1; d_mode = 0; err_pct = 0; take_mode = 1; f_len = 0;
    rnd_redir = 1'b0; redir_req = 1'b0; late_rv = 1'b0; redir_pc = '0;
    fetch_pc = 64'd1; instr_take = 1'b0; instr_len = 4'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rerr = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #3;
    chk("rst_valid", 80'(instr_valid), 80'd0);
    chk("rst_instr", instr, 80'd0);
    chk("rst_err",   80'(instr_err), 80'd0);
    chk("rst_req",   80'(mem_req), 80'd0);
    chk("rst_addr",  80'(mem_addr), 80'd0);
    fetch_pc = 64'd0;
    #9 rst_n = 1'b1;

    run_until_valid("a_tmo0", 20);
    take_mode = 2; f_len = 10;
    cycle();
    chk("a_win0", obs_instr, 80'h00010203040506070809);
    take_mode = 1;
    run_until_valid("a_tmo1", 20);
    cycle();
    chk("a_win1", obs_instr, 80'h0A0B0C0D0E0F10111213);

    wait_idle("b_idle");
    take_mode = 2; f_len = 10;
    cycle();
    take_mode = 1; d_mode = 2;
    n = 0;
    while (!(m_out == 1 && r_dly == 2) && n < 20) begin cycle(); n++; end
    if (!(m_out == 1 && r_dly == 2)) chk("b_tmo", 80'd0, 80'd1);
    redir_pc = 64'h13; redir_req = 1'b1; d_mode = 0;
    cycle();
    n = 0;
    do begin cycle(); n++; end while (!obs_req && n < 20);
    chk("b_addr", 80'(obs_addr), 80'h10);
    run_until_valid("b_tmo2", 20);
    cycle();
    chk("b_win", obs_instr, 80'h131415161718191A1B1C);

    for (int r = 0; r < 4; r++) begin
      foreach (lens[k]) begin
        run_until_valid("c_tmo", 20);
        take_mode = 2; f_len = lens[k];
        cycle();
        take_mode = 1;
      end
    end

    wait_idle("d_idle");
    redir_pc = 64'h40; redir_req = 1'b1; err_cd = 2;
    repeat (8) cycle();
    chk("d_err",   80'(obs_err), 80'd1);
    chk("d_valid", 80'(obs_valid), 80'd0);
    chk("d_req",   80'(obs_req), 80'd0);
    redir_pc = 64'h80; redir_req = 1'b1;
    cycle();
    run_until_valid("d_tmo", 20);
    cycle();
    chk("d_win", obs_instr, 80'h80818283848586878889);

    g_mode = 2;
    wait_idle("e_idle");
    redir_pc = 64'h100; redir_req = 1'b1;
    cycle();
    repeat (5) begin
      cycle();
      chk("e_req",  80'(obs_req), 80'd1);
      chk("e_addr", 80'(obs_addr), 80'h100);
    end
    g_mode = 1; d_mode = 3;
    cycle();
    @(negedge clk);
    fetch_pc = 64'h13; mem_rvalid = 1'b0; mem_gnt = 1'b0; instr_take = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("wr_valid", 80'(instr_valid), 80'd0);
    chk("wr_instr", instr, 80'd0);
    chk("wr_err",   80'(instr_err), 80'd0);
    chk("wr_req",   80'(mem_req), 80'd0);
    chk("wr_addr",  80'(mem_addr), 80'd0);
    model_reset();
    fetch_pc = 64'd0;
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    g_mode = 2; d_mode = 0; late_rv = 1'b1;
    cycle();
    g_mode = 1;
    run_until_valid("e_tmo", 20);
    cycle();
    chk("e_win", obs_instr, 80'h00010203040506070809);

    take_mode = 2; f_len = 0;
    cycle();
    take_mode = 1;
    cycle();
    chk("f_len0", obs_instr, 80'h00010203040506070809);
    take_mode = 2; f_len = 11;
    cycle();
    take_mode = 1;
    cycle();
    chk("f_len11", obs_instr, 80'h00010203040506070809);

    g_mode = 0; d_mode = -1; err_pct = 3; take_mode = 0; rnd_redir = 1'b1;
    repeat (3000) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
